// File: rtl/cpu_regfile.sv
// cpu_regfile: eight-entry register file sitting behind the CPU control unit.
// R0 doubles as the program counter and is exported on pc. Three operand
// buses (BUSA/BUSB/BUSC) are formed combinationally as the OR of every
// register whose drive enable is set. Sticky error flags record illegal
// control encodings: multiple simultaneous writes, and more than one driver
// enabled on any bus.
//
// Optional build macro: REGFILE_DEBUG_EN
//   Adds a debug read port (dbg_sel/dbg_data) and a 16-bit counter of
//   successful single-register writes (dbg_wr_cnt).
module cpu_regfile #(
    parameter int                WIDTH    = 16,
    parameter logic [WIDTH-1:0]  PC_RESET = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        write_en,
    input  logic [23:0]       output_en,
    input  logic [WIDTH-1:0]  reg_in,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  bus_a,
    output logic [WIDTH-1:0]  bus_b,
    output logic [WIDTH-1:0]  bus_c,
    output logic [WIDTH-1:0]  pc,
    output logic [3:0]        err
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [2:0]        dbg_sel,
    output logic [WIDTH-1:0]  dbg_data,
    output logic [15:0]       dbg_wr_cnt
`endif
);

    localparam int NREGS = 8;

    // Register storage and its next-state image.
    logic [WIDTH-1:0] r_q [NREGS];
    logic [WIDTH-1:0] r_d [NREGS];

    // Sticky error flags {multi_write, c_conflict, b_conflict, a_conflict}.
    logic [3:0] err_q;
    logic [3:0] err_d;

    // Per-bus enable vectors, regrouped from the interleaved output_en.
    logic [NREGS-1:0] en_a;
    logic [NREGS-1:0] en_b;
    logic [NREGS-1:0] en_c;

    // Per-register contributions to each bus (zero when not enabled).
    logic [WIDTH-1:0] term_a [NREGS];
    logic [WIDTH-1:0] term_b [NREGS];
    logic [WIDTH-1:0] term_c [NREGS];

    // Control decode.
    logic multi_write;
    logic single_write;
    logic conflict_a;
    logic conflict_b;
    logic conflict_c;

    // Clearing the lowest set bit leaves something only if two or more bits
    // were set; this avoids a full popcount for the ">= 2" tests.
    assign multi_write  = |(write_en & (write_en - 8'd1));
    assign single_write = (write_en != 8'd0) && !multi_write;
    assign conflict_a   = |(en_a & (en_a - 8'd1));
    assign conflict_b   = |(en_b & (en_b - 8'd1));
    assign conflict_c   = |(en_c & (en_c - 8'd1));

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_bus_sel
            // output_en bit 3i drives BUSA, 3i+1 BUSB, 3i+2 BUSC.
            assign en_a[gi]   = output_en[3*gi];
            assign en_b[gi]   = output_en[3*gi+1];
            assign en_c[gi]   = output_en[3*gi+2];
            assign term_a[gi] = en_a[gi] ? r_q[gi] : {WIDTH{1'b0}};
            assign term_b[gi] = en_b[gi] ? r_q[gi] : {WIDTH{1'b0}};
            assign term_c[gi] = en_c[gi] ? r_q[gi] : {WIDTH{1'b0}};
        end
    endgenerate

    // Wired-OR bus model: every enabled register contributes its bits.
    always_comb begin
        bus_a = {WIDTH{1'b0}};
        bus_b = {WIDTH{1'b0}};
        bus_c = {WIDTH{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            bus_a = bus_a | term_a[i];
            bus_b = bus_b | term_b[i];
            bus_c = bus_c | term_c[i];
        end
    end

    // Next register contents: only a clean one-hot write updates anything.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            r_d[i] = r_q[i];
        end
        if (single_write) begin
            for (int i = 0; i < NREGS; i++) begin
                if (write_en[i]) begin
                    r_d[i] = reg_in;
                end
            end
        end
    end

    // Next error flags: clear first, then OR in new errors so a set wins.
    always_comb begin
        err_d = err_clr ? 4'b0000 : err_q;
        err_d = err_d | {multi_write, conflict_c, conflict_b, conflict_a};
    end

    // State update with immediate reset to the power-on contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q[0] <= PC_RESET;
            for (int i = 1; i < NREGS; i++) begin
                r_q[i] <= {WIDTH{1'b0}};
            end
            err_q <= 4'b0000;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                r_q[i] <= r_d[i];
            end
            err_q <= err_d;
        end
    end

    // No bypass: pc and the buses always reflect the stored values.
    assign pc  = r_q[0];
    assign err = err_q;

`ifdef REGFILE_DEBUG_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] wr_cnt_d;

    // Count accepted writes; wraps naturally at 16 bits.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (single_write) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    // Counter register; independent of err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q <= 16'd0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign dbg_data   = r_q[dbg_sel];
    assign dbg_wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_regfile.sv
// Directed testbench for cpu_regfile (PC_RESET = 16'h0100).
module tb_cpu_regfile;

    logic        clk;
    logic        reset;
    logic [7:0]  write_en;
    logic [23:0] output_en;
    logic [15:0] reg_in;
    logic        err_clr;
    logic [15:0] bus_a;
    logic [15:0] bus_b;
    logic [15:0] bus_c;
    logic [15:0] pc;
    logic [3:0]  err;
`ifdef REGFILE_DEBUG_EN
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;
    logic [15:0] dbg_wr_cnt;
`endif

    int total = 0;
    int bad   = 0;

    cpu_regfile #(.WIDTH(16), .PC_RESET(16'h0100)) dut (
        .clk       (clk),
        .reset     (reset),
        .write_en  (write_en),
        .output_en (output_en),
        .reg_in    (reg_in),
        .err_clr   (err_clr),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .bus_c     (bus_c),
        .pc        (pc),
        .err       (err)
`ifdef REGFILE_DEBUG_EN
        ,
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .dbg_wr_cnt(dbg_wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-register write over one edge.
    task automatic wr(input int idx, input logic [15:0] v);
        write_en = 8'(1 << idx);
        reg_in   = v;
        tick();
        write_en = 8'h00;
    endtask

    // Enable mask for register idx onto bus (0=A, 1=B, 2=C).
    function automatic logic [23:0] oe(input int bus, input int idx);
        return 24'(1) << (3 * idx + bus);
    endfunction

    task automatic test_reset();
        output_en = 24'hFFFFFF;
        #1;
        total++; if (pc !== 16'h0100) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 16'h0100); end
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL reset_err: got %b want %b", err, 4'b0000); end
        total++; if (bus_a !== 16'h0100) begin bad++; $display("FAIL reset_bus_a_all: got %h want %h", bus_a, 16'h0100); end
        output_en = oe(1, 5);
        #1;
        total++; if (bus_b !== 16'h0000) begin bad++; $display("FAIL reset_r5: got %h want %h", bus_b, 16'h0000); end
        output_en = 24'h0;
        $display("txn reset: pc=%h err=%b", pc, err);
    endtask

    task automatic test_single_write();
        wr(3, 16'hBEEF);
        output_en = oe(0, 3);
        #1;
        total++; if (bus_a !== 16'hBEEF) begin bad++; $display("FAIL sw_bus_a: got %h want %h", bus_a, 16'hBEEF); end
        total++; if (bus_b !== 16'h0000) begin bad++; $display("FAIL sw_bus_b_idle: got %h want %h", bus_b, 16'h0000); end
        output_en = oe(1, 3);
        #1;
        total++; if (bus_b !== 16'hBEEF) begin bad++; $display("FAIL sw_bus_b: got %h want %h", bus_b, 16'hBEEF); end
        total++; if (pc !== 16'h0100) begin bad++; $display("FAIL sw_pc: got %h want %h", pc, 16'h0100); end
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL sw_err: got %b want %b", err, 4'b0000); end
`ifdef REGFILE_DEBUG_EN
        dbg_sel = 3'd3;
        #1;
        total++; if (dbg_data !== 16'hBEEF) begin bad++; $display("FAIL dbg_data: got %h want %h", dbg_data, 16'hBEEF); end
`endif
        output_en = 24'h0;
        $display("txn single_write: R3=%h", bus_b);
    endtask

    task automatic test_pc_increment();
        wr(0, 16'h0010);
        output_en = oe(0, 0);
        write_en  = 8'h01;
        reg_in    = 16'h0011;
        #1;
        total++; if (bus_a !== 16'h0010) begin bad++; $display("FAIL pc_pre_bus_a: got %h want %h", bus_a, 16'h0010); end
        total++; if (pc !== 16'h0010) begin bad++; $display("FAIL pc_pre_pc: got %h want %h", pc, 16'h0010); end
        tick();
        write_en = 8'h00;
        total++; if (bus_a !== 16'h0011) begin bad++; $display("FAIL pc_post_bus_a: got %h want %h", bus_a, 16'h0011); end
        total++; if (pc !== 16'h0011) begin bad++; $display("FAIL pc_post_pc: got %h want %h", pc, 16'h0011); end
        output_en = 24'h0;
        $display("txn pc_increment: pc=%h", pc);
    endtask

    task automatic test_multi_write();
        wr(1, 16'h1111);
        wr(2, 16'h2222);
        write_en = 8'h06;
        reg_in   = 16'h1234;
        tick();
        write_en  = 8'h00;
        output_en = oe(0, 1) | oe(1, 2);
        #1;
        total++; if (bus_a !== 16'h1111) begin bad++; $display("FAIL mw_r1: got %h want %h", bus_a, 16'h1111); end
        total++; if (bus_b !== 16'h2222) begin bad++; $display("FAIL mw_r2: got %h want %h", bus_b, 16'h2222); end
        total++; if (err !== 4'b1000) begin bad++; $display("FAIL mw_err: got %b want %b", err, 4'b1000); end
        output_en = 24'h0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL mw_clr: got %b want %b", err, 4'b0000); end
        // set and clear on the same edge: set wins
        write_en = 8'h06;
        err_clr  = 1'b1;
        tick();
        write_en = 8'h00;
        err_clr  = 1'b0;
        total++; if (err !== 4'b1000) begin bad++; $display("FAIL mw_set_wins: got %b want %b", err, 4'b1000); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL mw_clr2: got %b want %b", err, 4'b0000); end
        $display("txn multi_write: err=%b", err);
    endtask

    task automatic test_conflict();
        wr(1, 16'h00F0);
        wr(2, 16'h0F00);
        output_en = oe(0, 1) | oe(0, 2);
        #1;
        total++; if (bus_a !== 16'h0FF0) begin bad++; $display("FAIL cf_bus_a: got %h want %h", bus_a, 16'h0FF0); end
        total++; if (bus_b !== 16'h0000) begin bad++; $display("FAIL cf_bus_b: got %h want %h", bus_b, 16'h0000); end
        total++; if (bus_c !== 16'h0000) begin bad++; $display("FAIL cf_bus_c: got %h want %h", bus_c, 16'h0000); end
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL cf_err_pre: got %b want %b", err, 4'b0000); end
        tick();
        total++; if (err !== 4'b0001) begin bad++; $display("FAIL cf_err_a: got %b want %b", err, 4'b0001); end
        // C conflict plus a lone B driver (not a conflict)
        output_en = oe(2, 1) | oe(2, 2) | oe(1, 3);
        #1;
        total++; if (bus_c !== 16'h0FF0) begin bad++; $display("FAIL cf_bus_c2: got %h want %h", bus_c, 16'h0FF0); end
        total++; if (bus_b !== 16'hBEEF) begin bad++; $display("FAIL cf_bus_b2: got %h want %h", bus_b, 16'hBEEF); end
        tick();
        total++; if (err !== 4'b0101) begin bad++; $display("FAIL cf_err_c: got %b want %b", err, 4'b0101); end
        output_en = oe(1, 1) | oe(1, 3);
        tick();
        total++; if (err !== 4'b0111) begin bad++; $display("FAIL cf_err_b: got %b want %b", err, 4'b0111); end
        output_en = 24'h0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL cf_clr: got %b want %b", err, 4'b0000); end
        $display("txn conflict: err=%b", err);
    endtask

    task automatic test_back_to_back();
        wr(4, 16'hAAAA);
        wr(5, 16'h5555);
        wr(6, 16'h0F0F);
        wr(7, 16'hF0F0);
        // reg_in changes with no write enable: nothing may change
        reg_in = 16'hDEAD;
        tick();
        output_en = oe(1, 4);
        #1;
        total++; if (bus_b !== 16'hAAAA) begin bad++; $display("FAIL b2b_r4: got %h want %h", bus_b, 16'hAAAA); end
        output_en = oe(1, 5);
        #1;
        total++; if (bus_b !== 16'h5555) begin bad++; $display("FAIL b2b_r5: got %h want %h", bus_b, 16'h5555); end
        output_en = oe(2, 6);
        #1;
        total++; if (bus_c !== 16'h0F0F) begin bad++; $display("FAIL b2b_r6: got %h want %h", bus_c, 16'h0F0F); end
        output_en = oe(2, 7);
        #1;
        total++; if (bus_c !== 16'hF0F0) begin bad++; $display("FAIL b2b_r7: got %h want %h", bus_c, 16'hF0F0); end
        total++; if (pc !== 16'h0011) begin bad++; $display("FAIL b2b_pc: got %h want %h", pc, 16'h0011); end
        output_en = 24'h0;
        $display("txn back_to_back: r4..r7 written");
    endtask

    task automatic test_async_reset();
        // leave a sticky error pending so reset has something to clear
        write_en = 8'h30;
        tick();
        write_en = 8'h00;
        total++; if (err !== 4'b1000) begin bad++; $display("FAIL ar_err_pre: got %b want %b", err, 4'b1000); end
        #2;
        reset = 1'b1;
        output_en = 24'hFFFFFF;
        #1;
        total++; if (pc !== 16'h0100) begin bad++; $display("FAIL ar_pc: got %h want %h", pc, 16'h0100); end
        total++; if (err !== 4'b0000) begin bad++; $display("FAIL ar_err: got %b want %b", err, 4'b0000); end
        total++; if (bus_c !== 16'h0100) begin bad++; $display("FAIL ar_bus_c_all: got %h want %h", bus_c, 16'h0100); end
        output_en = oe(0, 3);
        #1;
        total++; if (bus_a !== 16'h0000) begin bad++; $display("FAIL ar_r3: got %h want %h", bus_a, 16'h0000); end
        output_en = 24'h0;
        #1;
        reset = 1'b0;
        $display("txn async_reset: pc=%h err=%b", pc, err);
    endtask

`ifdef REGFILE_DEBUG_EN
    task automatic test_debug();
        total++; if (dbg_wr_cnt !== 16'd0) begin bad++; $display("FAIL dbg_cnt_reset: got %0d want %0d", dbg_wr_cnt, 0); end
        wr(1, 16'h0001);
        wr(2, 16'h0002);
        wr(3, 16'h0003);
        write_en = 8'h03;
        tick();
        write_en = 8'h00;
        total++; if (dbg_wr_cnt !== 16'd3) begin bad++; $display("FAIL dbg_cnt: got %0d want %0d", dbg_wr_cnt, 3); end
        $display("txn debug: cnt=%0d", dbg_wr_cnt);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        write_en  = 8'h00;
        output_en = 24'h0;
        reg_in    = 16'h0000;
        err_clr   = 1'b0;
`ifdef REGFILE_DEBUG_EN
        dbg_sel   = 3'd0;
`endif
        tick();
        #2;
        test_reset();
        reset = 1'b0;
        tick();
        test_single_write();
        test_pc_increment();
        test_multi_write();
        test_conflict();
        test_back_to_back();
        test_async_reset();
`ifdef REGFILE_DEBUG_EN
        test_debug();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
